emulador_hcsr04: RTL and testbench

//  Emulates the HC-SR04 ultrasonic sensor: accepts trigger from interface_hcsr04 and answers with an echo pulse.

---
 rtl/hcsr04_pkg.sv | 29 ++
 rtl/emulador_hcsr04_timer.sv | 28 ++
 rtl/emulador_hcsr04.sv | 188 ++++++++++++++++++
 tb/tb_emulador_hcsr04.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hcsr04_pkg.sv
// Shared definitions for the HC-SR04 emulator: state codes, default timing
// constants and the echo-width datapath width.
package hcsr04_pkg;

  localparam int W_W = 21;

  localparam logic [3:0] EST_IDLE    = 4'd0;
  localparam logic [3:0] EST_TRIG_HI = 4'd1;
  localparam logic [3:0] EST_BURST   = 4'd2;
  localparam logic [3:0] EST_ECHO    = 4'd3;
  localparam logic [3:0] EST_HOLDOFF = 4'd4;

  typedef enum logic [3:0] {
    ST_IDLE    = EST_IDLE,
    ST_TRIG_HI = EST_TRIG_HI,
    ST_BURST   = EST_BURST,
    ST_ECHO    = EST_ECHO,
    ST_HOLDOFF = EST_HOLDOFF
  } estado_t;

  // Defaults assume a 50 MHz clock.
  localparam int unsigned TRIG_MIN_CYC_DEF = 500;
  localparam int unsigned BURST_CYC_DEF    = 10000;
  localparam int unsigned CYC_PER_CM_DEF   = 2941;
  localparam int unsigned MAX_CM_DEF       = 400;
  localparam int unsigned TIMEOUT_CYC_DEF  = 1900000;
  localparam int unsigned HOLDOFF_CYC_DEF  = 500000;

endpackage

// File: rtl/emulador_hcsr04_timer.sv
// Loadable down-counter that saturates at zero; one instance times every
// phase of the emulator (trigger width, burst, echo, hold-off).
module emulador_hcsr04_timer
  import hcsr04_pkg::*;
(
  input  logic           clock,
  input  logic           reset,
  input  logic           load,
  input  logic           en,
  input  logic [W_W-1:0] value,
  output logic           zero
);

  logic [W_W-1:0] count;

  always_ff @(posedge clock) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (en && !zero) begin
      count <= count - W_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/emulador_hcsr04.sv
// HC-SR04 ultrasonic sensor emulator: answers a valid trigger with an echo
// pulse whose width encodes a distance. Define EMULADOR_HCSR04_RUIDO_EN to add
// 0..15 cycles of LFSR jitter to object echoes.
module emulador_hcsr04
  import hcsr04_pkg::*;
#(
  parameter int unsigned TRIG_MIN_CYC = TRIG_MIN_CYC_DEF,
  parameter int unsigned BURST_CYC    = BURST_CYC_DEF,
  parameter int unsigned CYC_PER_CM   = CYC_PER_CM_DEF,
  parameter int unsigned MAX_CM       = MAX_CM_DEF,
  parameter int unsigned TIMEOUT_CYC  = TIMEOUT_CYC_DEF,
  parameter int unsigned HOLDOFF_CYC  = HOLDOFF_CYC_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       trigger,
  input  logic [8:0] distancia,
  input  logic       objeto,
  output logic       echo,
  output logic       ocupado,
  output logic [7:0] medidas,
  output logic [3:0] db_estado
);

  localparam logic [W_W-1:0] LD_TRIG  = W_W'(TRIG_MIN_CYC - 1);
  // Burst is timed from the synchronized trigger fall, one cycle of which is
  // spent in TRIG_HI detecting it.
  localparam logic [W_W-1:0] LD_BURST = W_W'(BURST_CYC - 2);
  localparam logic [W_W-1:0] LD_HOLD  = W_W'(HOLDOFF_CYC - 1);
  localparam logic [W_W-1:0] CPC      = W_W'(CYC_PER_CM);
  localparam logic [W_W-1:0] TOUT     = W_W'(TIMEOUT_CYC);
  localparam logic [8:0]     MAXD     = 9'(MAX_CM);

  function automatic logic [W_W-1:0] calc_w(input logic [8:0] d, input logic obj,
                                            input logic [3:0] jit);
    logic [W_W-1:0] w;
    if (!obj || d > MAXD) begin
      w = TOUT;
    end else if (d < 9'd2) begin
      w = (CPC << 1) + {17'd0, jit};
    end else begin
      w = ({12'd0, d} * CPC) + {17'd0, jit};
    end
    return w;
  endfunction

  estado_t        estado;
  logic           trig_p0, t_s_p1, t_s_p2;
  logic           t_rise, t_fall, acc;
  logic           tmr_load, tmr_en, tmr_zero;
  logic [W_W-1:0] tmr_value;
  logic [W_W-1:0] w_reg;
  logic [3:0]     jitter;

  // Stage p0/p1: two-flop synchronizer; p2 holds the previous synchronized value
  always_ff @(posedge clock) begin
    if (!reset) begin
      trig_p0 <= 1'b0;
      t_s_p1  <= 1'b0;
      t_s_p2  <= 1'b0;
    end else begin
      trig_p0 <= trigger;
      t_s_p1  <= trig_p0;
      t_s_p2  <= t_s_p1;
    end
  end

  assign t_rise = t_s_p1 & ~t_s_p2;
  assign t_fall = ~t_s_p1 & t_s_p2;
  assign acc    = (estado == ST_TRIG_HI) && t_fall && tmr_zero;

`ifdef EMULADOR_HCSR04_RUIDO_EN
  logic [7:0] lfsr;

  always_ff @(posedge clock) begin
    if (!reset) begin
      lfsr <= 8'hA5;
    end else if (acc) begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

  assign jitter = lfsr[3:0];
`else
  assign jitter = 4'd0;
`endif

  // Width is captured at the accepted fall so later input changes cannot alter it.
  always_ff @(posedge clock) begin
    if (acc) begin
      w_reg <= calc_w(distancia, objeto, jitter);
    end
  end

  always_comb begin
    tmr_load  = 1'b0;
    tmr_en    = 1'b0;
    tmr_value = '0;
    unique case (estado)
      ST_IDLE: begin
        if (t_rise) begin
          tmr_load  = 1'b1;
          tmr_value = LD_TRIG;
        end
      end
      ST_TRIG_HI: begin
        tmr_en = t_s_p1;
        if (acc) begin
          tmr_load  = 1'b1;
          tmr_value = LD_BURST;
        end
      end
      ST_BURST: begin
        tmr_en = 1'b1;
        if (tmr_zero) begin
          tmr_load  = 1'b1;
          tmr_value = w_reg - W_W'(1);
        end
      end
      ST_ECHO: begin
        tmr_en = 1'b1;
        if (tmr_zero) begin
          tmr_load  = 1'b1;
          tmr_value = LD_HOLD;
        end
      end
      ST_HOLDOFF: tmr_en = 1'b1;
      default: ;
    endcase
  end

  emulador_hcsr04_timer u_timer (
    .clock (clock),
    .reset (reset),
    .load  (tmr_load),
    .en    (tmr_en),
    .value (tmr_value),
    .zero  (tmr_zero)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      estado  <= ST_IDLE;
      echo    <= 1'b0;
      ocupado <= 1'b0;
      medidas <= '0;
    end else begin
      unique case (estado)
        ST_IDLE: begin
          if (t_rise) estado <= ST_TRIG_HI;
        end
        ST_TRIG_HI: begin
          if (t_fall) begin
            if (tmr_zero) begin
              estado  <= ST_BURST;
              ocupado <= 1'b1;
            end else begin
              estado <= ST_IDLE;
            end
          end
        end
        ST_BURST: begin
          if (tmr_zero) begin
            estado <= ST_ECHO;
            echo   <= 1'b1;
          end
        end
        ST_ECHO: begin
          if (tmr_zero) begin
            estado  <= ST_HOLDOFF;
            echo    <= 1'b0;
            medidas <= medidas + 8'd1;
          end
        end
        ST_HOLDOFF: begin
          if (tmr_zero) begin
            estado  <= ST_IDLE;
            ocupado <= 1'b0;
          end
        end
        default: estado <= ST_IDLE;
      endcase
    end
  end

  assign db_estado = estado;

endmodule

// File: tb/tb_emulador_hcsr04.sv
// Bench for emulador_hcsr04 with shortened timing: directed triggers push
// expected echoes into a queue that a negedge monitor checks.
module tb_emulador_hcsr04;

  localparam int TMIN  = 5;
  localparam int BURST = 20;
  localparam int CPC   = 3;
  localparam int MAXCM = 400;
  localparam int TOUT  = 1500;
  localparam int HOLD  = 60;
  localparam int IDLE_BUDGET = 4000;

  logic       clock, reset, trigger, objeto;
  logic [8:0] distancia;
  logic       echo, ocupado;
  logic [7:0] medidas;
  logic [3:0] db_estado;

  emulador_hcsr04 #(
    .TRIG_MIN_CYC (TMIN),
    .BURST_CYC    (BURST),
    .CYC_PER_CM   (CPC),
    .MAX_CM       (MAXCM),
    .TIMEOUT_CYC  (TOUT),
    .HOLDOFF_CYC  (HOLD)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .trigger   (trigger),
    .distancia (distancia),
    .objeto    (objeto),
    .echo      (echo),
    .ocupado   (ocupado),
    .medidas   (medidas),
    .db_estado (db_estado)
  );

  typedef struct {
    int rise;
    int width;
    int med;
    bit abort;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   exp_med  = 0;
  bit   mon_echo_q = 1'b0;
  bit   mon_orphan = 1'b0;
  int   mon_rise   = 0;
  exp_t mon_e;
`ifdef EMULADOR_HCSR04_RUIDO_EN
  logic [7:0] lfsr_m = 8'hA5;
`endif

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, %0d expectations pending", sb.size());
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic wait_state(input logic [3:0] s, input int budget);
    int n = 0;
    while (db_estado != s && n < budget) begin
      @(negedge clock);
      n++;
    end
    check($sformatf("wait_state_%0d", s), int'(db_estado), int'(s));
  endtask

  // Trigger high for 'width' cycles; an accepted trigger queues its echo.
  task automatic pulse_trig(input int width, input logic [8:0] d, input logic obj,
                            input bit accept, input int w_hand, input bit abort);
    exp_t e;
    int   fall_cyc;
    @(posedge clock);
    #1;
    distancia = d;
    objeto    = obj;
    trigger   = 1'b1;
    repeat (width) @(posedge clock);
    #1;
    if (width > 50) begin
      check("held_state", int'(db_estado), 1);
      check("held_echo", int'(echo), 0);
    end
    trigger  = 1'b0;
    fall_cyc = cyc;
    if (accept) begin
      e.rise  = fall_cyc + BURST + 2;
      e.width = w_hand;
      e.abort = abort;
`ifdef EMULADOR_HCSR04_RUIDO_EN
      if (obj && d <= 9'(MAXCM)) e.width += int'(lfsr_m[3:0]);
      lfsr_m = {lfsr_m[6:0], ^(lfsr_m & 8'hB8)};
`endif
      if (!abort) exp_med = (exp_med + 1) % 256;
      e.med = exp_med;
      sb.push_back(e);
    end
    repeat (4) @(posedge clock);
    #1;
    distancia = ~d;
    objeto    = ~obj;
    if (accept) begin
      check("burst_state", int'(db_estado), 2);
      check("burst_ocupado", int'(ocupado), 1);
    end
  endtask

  task automatic trig_ok(input logic [8:0] d, input logic obj, input int w_hand);
    wait_state(4'd0, IDLE_BUDGET);
    pulse_trig(8, d, obj, 1'b1, w_hand, 1'b0);
  endtask

  initial begin
    forever begin
      @(negedge clock);
      if (echo && !mon_echo_q) begin
        mon_rise = cyc;
        if (sb.size() == 0) begin
          mon_orphan = 1'b1;
          check("unexpected_echo_pending", sb.size(), 1);
        end
      end
      if (!echo && mon_echo_q) begin
        if (mon_orphan) begin
          mon_orphan = 1'b0;
        end else begin
          mon_e = sb.pop_front();
          check("echo_rise_cycle", mon_rise, mon_e.rise);
          if (mon_e.abort) begin
            check("abort_reset_low", int'(reset), 0);
            check("abort_medidas", int'(medidas), 0);
          end else begin
            check("echo_width", cyc - mon_rise, mon_e.width);
            check("medidas", int'(medidas), mon_e.med);
          end
        end
      end
      mon_echo_q = echo;
    end
  end

  initial begin
    int n;
    reset     = 1'b0;
    trigger   = 1'b0;
    distancia = 9'd0;
    objeto    = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_echo", int'(echo), 0);
    check("rst_ocupado", int'(ocupado), 0);
    check("rst_medidas", int'(medidas), 0);
    check("rst_estado", int'(db_estado), 0);
    reset = 1'b1;

    // Basic echo, then short/boundary trigger widths
    trig_ok(9'd10, 1'b1, 30);
    wait_state(4'd0, IDLE_BUDGET);
    pulse_trig(3, 9'd10, 1'b1, 1'b0, 0, 1'b0);
    repeat (10) @(posedge clock);
    #1;
    check("short_trig_state", int'(db_estado), 0);
    check("short_trig_ocupado", int'(ocupado), 0);
    check("short_trig_medidas", int'(medidas), exp_med);
    pulse_trig(TMIN - 1, 9'd10, 1'b1, 1'b0, 0, 1'b0);
    repeat (10) @(posedge clock);
    #1;
    check("min1_trig_state", int'(db_estado), 0);
    pulse_trig(TMIN, 9'd1, 1'b1, 1'b1, 6, 1'b0);

    // No object, out of range, minimum and maximum distances
    trig_ok(9'd10, 1'b0, TOUT);
    trig_ok(9'd450, 1'b1, TOUT);
    trig_ok(9'd0, 1'b1, 6);
    trig_ok(9'd400, 1'b1, 1200);
    trig_ok(9'd401, 1'b1, TOUT);

    // Triggers during ECHO and HOLDOFF are dropped
    trig_ok(9'd20, 1'b1, 60);
    wait_state(4'd3, 200);
    pulse_trig(8, 9'd5, 1'b1, 1'b0, 0, 1'b0);
    wait_state(4'd4, 200);
    pulse_trig(8, 9'd5, 1'b1, 1'b0, 0, 1'b0);
    trig_ok(9'd7, 1'b1, 21);

    // Trigger held high stays in TRIG_HI; its release is a valid trigger
    wait_state(4'd0, IDLE_BUDGET);
    pulse_trig(100, 9'd15, 1'b1, 1'b1, 45, 1'b0);

    // Reset in the middle of an echo
    wait_state(4'd0, IDLE_BUDGET);
    pulse_trig(8, 9'd100, 1'b1, 1'b1, 300, 1'b1);
    wait_state(4'd3, 200);
    repeat (5) @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;
    check("midrst_echo", int'(echo), 0);
    check("midrst_estado", int'(db_estado), 0);
    check("midrst_medidas", int'(medidas), 0);
    check("midrst_ocupado", int'(ocupado), 0);
    exp_med = 0;
`ifdef EMULADOR_HCSR04_RUIDO_EN
    lfsr_m = 8'hA5;
`endif
    @(posedge clock);
    #1;
    reset = 1'b1;
    trig_ok(9'd3, 1'b1, 9);

    // Repeated triggers at one distance
    for (int i = 0; i < 3; i++) begin
      trig_ok(9'd10, 1'b1, 30);
    end

    n = 0;
    while (sb.size() != 0 && n < IDLE_BUDGET) begin
      @(negedge clock);
      n++;
    end
    check("scoreboard_drained", sb.size(), 0);
    wait_state(4'd0, IDLE_BUDGET);
    check("final_medidas", int'(medidas), exp_med);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
